// File: rtl/fft_iter_sequencer.sv
// Stage/iteration sequencer for an in-place radix-2 DIT FFT.
// Counts butterflies (b) within a stage and stages (s) within a transform.
// Top, bottom and twiddle addresses are decoded combinationally from b and s.
module fft_iter_sequencer #(
    parameter int LOG2_N       = 5,
    parameter bit AUTO_ADVANCE = 1'b1,
    localparam int ITER_W      = LOG2_N - 1,
    localparam int STAGE_W     = (LOG2_N > 2) ? $clog2(LOG2_N) : 1,
    localparam int ADDR_W      = LOG2_N,
    localparam int TW_W        = LOG2_N - 1
) (
    input  logic               clk,
    input  logic               n_reset,
    input  logic               start,
    input  logic               abort,
    input  logic               iteration_strobe,
    input  logic               stage_go,
    output logic               busy,
    output logic               stage_strobe,
    output logic               done,
    output logic [ITER_W-1:0]  iteration_count_out,
    output logic [STAGE_W-1:0] stage_count_out,
    output logic [ADDR_W-1:0]  top_addr,
    output logic [ADDR_W-1:0]  bot_addr,
    output logic [TW_W-1:0]    tw_addr
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_WAIT} state_t;

    // b == N/2-1 is all ones in ITER_W bits
    localparam logic [ITER_W-1:0]  B_LAST = '1;
    localparam logic [STAGE_W-1:0] S_LAST = STAGE_W'(LOG2_N - 1);

    state_t               state_q, state_d;
    logic [ITER_W-1:0]    b_q, b_d;
    logic [STAGE_W-1:0]   s_q, s_d;
    logic                 busy_q, busy_d;
    logic                 stage_strobe_q, stage_strobe_d;
    logic                 done_q, done_d;

    // Next-state and counter logic; abort dominates every other input.
    // A start seen while done is still high is the tail of the finishing
    // transform and is dropped.
    always_comb begin
        state_d        = state_q;
        b_d            = b_q;
        s_d            = s_q;
        stage_strobe_d = 1'b0;
        done_d         = 1'b0;
        if (abort) begin
            state_d = S_IDLE;
            b_d     = '0;
            s_d     = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start && !done_q) begin
                        state_d = S_RUN;
                        b_d     = '0;
                        s_d     = '0;
                    end
                end
                S_RUN: begin
                    if (iteration_strobe) begin
                        if (b_q == B_LAST) begin
                            b_d            = '0;
                            stage_strobe_d = 1'b1;
                            if (s_q == S_LAST) begin
                                s_d     = '0;
                                state_d = S_IDLE;
                                done_d  = 1'b1;
                            end else begin
                                s_d     = s_q + STAGE_W'(1);
                                state_d = AUTO_ADVANCE ? S_RUN : S_WAIT;
                            end
                        end else begin
                            b_d = b_q + ITER_W'(1);
                        end
                    end
                end
                S_WAIT: begin
                    if (stage_go) state_d = S_RUN;
                end
                default: state_d = S_IDLE;
            endcase
        end
        busy_d = (state_d != S_IDLE);
    end

    // State, counters and registered status pulses
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q        <= S_IDLE;
            b_q            <= '0;
            s_q            <= '0;
            busy_q         <= 1'b0;
            stage_strobe_q <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            b_q            <= b_d;
            s_q            <= s_d;
            busy_q         <= busy_d;
            stage_strobe_q <= stage_strobe_d;
            done_q         <= done_d;
        end
    end

    logic [ADDR_W-1:0]  b_ext, span, pos, grp, top;
    logic [STAGE_W-1:0] tw_shift;

    // Butterfly address decode: insert a zero at bit s of b for the top
    // operand, the pair partner sits span above, twiddle stride halves per stage.
    always_comb begin
        b_ext    = ADDR_W'(b_q);
        span     = ADDR_W'(1) << s_q;
        pos      = b_ext & (span - ADDR_W'(1));
        grp      = b_ext >> s_q;
        top      = ((grp << s_q) << 1) | pos;
        tw_shift = S_LAST - s_q;
    end

    assign busy                = busy_q;
    assign stage_strobe        = stage_strobe_q;
    assign done                = done_q;
    assign iteration_count_out = b_q;
    assign stage_count_out     = s_q;
    assign top_addr            = top;
    assign bot_addr            = top + span;
    assign tw_addr             = pos[TW_W-1:0] << tw_shift;

endmodule

// File: tb/tb_fft_iter_sequencer.sv
// Bench for fft_iter_sequencer: three instances (N=8 auto, N=8 held, N=32 auto)
// compared every cycle against a transaction-level model of the sequencer.
module tb_fft_iter_sequencer;

    logic clk = 1'b0;
    logic n_reset;
    always #5 clk = ~clk;

    int vecs = 0;
    int miss = 0;

    // ---------------- DUT A: LOG2_N=3, AUTO_ADVANCE=1 ----------------
    logic st_a, ab_a, is_a, go_a, busy_a, ss_a, dn_a;
    logic [1:0] it_a, sc_a, tw_a;
    logic [2:0] top_a, bot_a;
    fft_iter_sequencer #(.LOG2_N(3), .AUTO_ADVANCE(1'b1)) u_a (
        .clk(clk), .n_reset(n_reset), .start(st_a), .abort(ab_a),
        .iteration_strobe(is_a), .stage_go(go_a), .busy(busy_a),
        .stage_strobe(ss_a), .done(dn_a), .iteration_count_out(it_a),
        .stage_count_out(sc_a), .top_addr(top_a), .bot_addr(bot_a), .tw_addr(tw_a));

    // ---------------- DUT B: LOG2_N=3, AUTO_ADVANCE=0 ----------------
    logic st_b, ab_b, is_b, go_b, busy_b, ss_b, dn_b;
    logic [1:0] it_b, sc_b, tw_b;
    logic [2:0] top_b, bot_b;
    fft_iter_sequencer #(.LOG2_N(3), .AUTO_ADVANCE(1'b0)) u_b (
        .clk(clk), .n_reset(n_reset), .start(st_b), .abort(ab_b),
        .iteration_strobe(is_b), .stage_go(go_b), .busy(busy_b),
        .stage_strobe(ss_b), .done(dn_b), .iteration_count_out(it_b),
        .stage_count_out(sc_b), .top_addr(top_b), .bot_addr(bot_b), .tw_addr(tw_b));

    // ---------------- DUT C: LOG2_N=5 (defaults) ----------------
    logic st_c, ab_c, is_c, go_c, busy_c, ss_c, dn_c;
    logic [3:0] it_c, tw_c;
    logic [2:0] sc_c;
    logic [4:0] top_c, bot_c;
    fft_iter_sequencer u_c (
        .clk(clk), .n_reset(n_reset), .start(st_c), .abort(ab_c),
        .iteration_strobe(is_c), .stage_go(go_c), .busy(busy_c),
        .stage_strobe(ss_c), .done(dn_c), .iteration_count_out(it_c),
        .stage_count_out(sc_c), .top_addr(top_c), .bot_addr(bot_c), .tw_addr(tw_c));

    // Observed outputs packed into one common layout
    logic [46:0] obs_a, obs_b, obs_c;
    assign obs_a = {busy_a, ss_a, dn_a, 10'(it_a), 4'(sc_a), 10'(top_a), 10'(bot_a), 10'(tw_a)};
    assign obs_b = {busy_b, ss_b, dn_b, 10'(it_b), 4'(sc_b), 10'(top_b), 10'(bot_b), 10'(tw_b)};
    assign obs_c = {busy_c, ss_c, dn_c, 10'(it_c), 4'(sc_c), 10'(top_c), 10'(bot_c), 10'(tw_c)};

    // ---------------- reference model ----------------
    // st: 0 idle, 1 running, 2 holding between stages
    typedef struct packed { int st; int b; int s; bit ss; bit dn; } mdl_t;
    mdl_t ma, mb, mc;
    localparam mdl_t M_RST = '{st: 0, b: 0, s: 0, ss: 1'b0, dn: 1'b0};

    function automatic mdl_t mstep(mdl_t m, bit start, bit abort, bit strobe, bit go, int l2n, bit aa);
        mdl_t n;
        n    = m;
        n.ss = 1'b0;
        n.dn = 1'b0;
        if (abort) begin
            n.st = 0; n.b = 0; n.s = 0;
        end else if (m.st == 0) begin
            if (start && !m.dn) begin n.st = 1; n.b = 0; n.s = 0; end
        end else if (m.st == 1) begin
            if (strobe) begin
                if (m.b == (1 << (l2n - 1)) - 1) begin
                    n.b  = 0;
                    n.ss = 1'b1;
                    if (m.s == l2n - 1) begin n.s = 0; n.st = 0; n.dn = 1'b1; end
                    else begin n.s = m.s + 1; n.st = aa ? 1 : 2; end
                end else n.b = m.b + 1;
            end
        end else if (go) n.st = 1;
        return n;
    endfunction

    // Top operand = b-th index (ascending) whose bit s is clear; partner is span above.
    function automatic logic [46:0] exp_vec(mdl_t m, int l2n);
        int cnt, top, span, tw;
        span = 1 << m.s;
        cnt  = 0;
        top  = 0;
        for (int i = 0; i < (1 << l2n); i++) begin
            if (((i >> m.s) & 1) == 0) begin
                if (cnt == m.b) top = i;
                cnt++;
            end
        end
        tw = (top % span) * ((1 << l2n) / (2 * span));
        return {m.st != 0, m.ss, m.dn, 10'(m.b), 4'(m.s), 10'(top), 10'(top + span), 10'(tw)};
    endfunction

    // Advance one clock; models consume the inputs held across that edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (!n_reset) begin
            ma = M_RST; mb = M_RST; mc = M_RST;
        end else begin
            ma = mstep(ma, st_a, ab_a, is_a, go_a, 3, 1'b1);
            mb = mstep(mb, st_b, ab_b, is_b, go_b, 3, 1'b0);
            mc = mstep(mc, st_c, ab_c, is_c, go_c, 5, 1'b1);
        end
    endtask

    task automatic test_reset();
        int guard;
        n_reset = 1'b0;
        #3;
        if (obs_a !== exp_vec(M_RST, 3)) begin miss++; $display("FAIL reset_a: got %h want %h", obs_a, exp_vec(M_RST, 3)); end
        vecs++;
        if (obs_b !== exp_vec(M_RST, 3)) begin miss++; $display("FAIL reset_b: got %h want %h", obs_b, exp_vec(M_RST, 3)); end
        vecs++;
        if (obs_c !== exp_vec(M_RST, 5)) begin miss++; $display("FAIL reset_c: got %h want %h", obs_c, exp_vec(M_RST, 5)); end
        vecs++;
        #4 n_reset = 1'b1;
        ma = M_RST; mb = M_RST; mc = M_RST;
        // walk C to s=2, b=5 with random strobe gaps
        st_c = 1'b1; tick(); st_c = 1'b0;
        guard = 0;
        while (!(mc.st == 1 && mc.s == 2 && mc.b == 5) && guard < 400) begin
            is_c = 1'($urandom % 2);
            tick();
            if (obs_c !== exp_vec(mc, 5)) begin miss++; $display("FAIL reset_walk_c: got %h want %h", obs_c, exp_vec(mc, 5)); end
            vecs++;
            guard++;
        end
        is_c = 1'b0;
        if (guard >= 400) begin miss++; $display("FAIL reset_walk_bound: got %0d cycles want <400", guard); end
        vecs++;
        #2 n_reset = 1'b0;
        #1;
        if (obs_c !== exp_vec(M_RST, 5)) begin miss++; $display("FAIL reset_async_c: got %h want %h", obs_c, exp_vec(M_RST, 5)); end
        vecs++;
        if (bot_c !== 5'd1) begin miss++; $display("FAIL reset_bot_addr: got %0d want 1", bot_c); end
        vecs++;
        #2 n_reset = 1'b1;
        ma = M_RST; mb = M_RST; mc = M_RST;
    endtask

    task automatic test_full_transform();
        st_a = 1'b1; tick(); st_a = 1'b0;
        if (busy_a !== 1'b1) begin miss++; $display("FAIL full_busy_rise: got %b want 1", busy_a); end
        vecs++;
        is_a = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (obs_a !== exp_vec(ma, 3)) begin miss++; $display("FAIL full_model k=%0d: got %h want %h", k, obs_a, exp_vec(ma, 3)); end
            vecs++;
            if (ss_a !== 1'(k % 4 == 0)) begin miss++; $display("FAIL full_stage_strobe k=%0d: got %b want %b", k, ss_a, k % 4 == 0); end
            vecs++;
            if (dn_a !== 1'(k == 12) || busy_a !== 1'(k != 12)) begin
                miss++; $display("FAIL full_done_busy k=%0d: got %b%b want %b%b", k, dn_a, busy_a, k == 12, k != 12);
            end
            vecs++;
        end
        is_a = 1'b0;
        tick();
        if (dn_a !== 1'b0 || ss_a !== 1'b0 || busy_a !== 1'b0) begin miss++; $display("FAIL full_after: got %b%b%b want 000", dn_a, ss_a, busy_a); end
        vecs++;
    endtask

    task automatic test_addr_table();
        int ts[4]   = '{0, 1, 1, 2};
        int tbi[4]  = '{3, 1, 2, 3};
        int ttop[4] = '{6, 1, 4, 3};
        int tbot[4] = '{7, 3, 6, 7};
        int ttw[4]  = '{0, 2, 0, 3};
        logic [3:0] seen = '0;
        bit fin = 1'b0;
        st_a = 1'b1; tick(); st_a = 1'b0;
        for (int c = 0; c < 300 && !fin; c++) begin
            is_a = 1'($urandom % 2);
            tick();
            if (obs_a !== exp_vec(ma, 3)) begin miss++; $display("FAIL addr_model: got %h want %h", obs_a, exp_vec(ma, 3)); end
            vecs++;
            for (int j = 0; j < 4; j++) begin
                if (ma.st == 1 && ma.s == ts[j] && ma.b == tbi[j]) begin
                    seen[j] = 1'b1;
                    if (top_a !== 3'(ttop[j]) || bot_a !== 3'(tbot[j]) || tw_a !== 2'(ttw[j])) begin
                        miss++; $display("FAIL addr_table s=%0d b=%0d: got %0d/%0d/%0d want %0d/%0d/%0d",
                                         ts[j], tbi[j], top_a, bot_a, tw_a, ttop[j], tbot[j], ttw[j]);
                    end
                    vecs++;
                end
            end
            fin = ma.dn;
        end
        is_a = 1'b0;
        if (seen !== 4'hF || !fin) begin miss++; $display("FAIL addr_coverage: got %b done=%b want 1111 done=1", seen, fin); end
        vecs++;
        tick();
    endtask

    task automatic test_wait_hold();
        st_b = 1'b1; tick(); st_b = 1'b0;
        is_b = 1'b1;
        for (int k = 0; k < 7; k++) begin
            tick();
            if (obs_b !== exp_vec(mb, 3)) begin miss++; $display("FAIL wait_model k=%0d: got %h want %h", k, obs_b, exp_vec(mb, 3)); end
            vecs++;
        end
        is_b = 1'b0;
        if (it_b !== 2'd0 || sc_b !== 2'd1 || busy_b !== 1'b1) begin
            miss++; $display("FAIL wait_hold: got b=%0d s=%0d busy=%b want b=0 s=1 busy=1", it_b, sc_b, busy_b);
        end
        vecs++;
        go_b = 1'b1; tick(); go_b = 1'b0;
        is_b = 1'b1; tick(); is_b = 1'b0;
        if (it_b !== 2'd1 || sc_b !== 2'd1) begin miss++; $display("FAIL wait_release: got b=%0d s=%0d want b=1 s=1", it_b, sc_b); end
        vecs++;
        if (obs_b !== exp_vec(mb, 3)) begin miss++; $display("FAIL wait_release_model: got %h want %h", obs_b, exp_vec(mb, 3)); end
        vecs++;
    endtask

    task automatic test_simultaneous();
        is_b = 1'b1; tick(); tick();
        ab_b = 1'b1; tick(); ab_b = 1'b0; is_b = 1'b0;
        if (busy_b !== 1'b0 || it_b !== 2'd0 || sc_b !== 2'd0 || ss_b !== 1'b0) begin
            miss++; $display("FAIL abort_strobe: got busy=%b b=%0d s=%0d ss=%b want 0 0 0 0", busy_b, it_b, sc_b, ss_b);
        end
        vecs++;
        st_a = 1'b1; tick(); st_a = 1'b0;
        is_a = 1'b1; tick(); tick(); tick(); is_a = 1'b0;
        st_a = 1'b1; tick(); tick(); st_a = 1'b0;
        if (it_a !== 2'd3 || sc_a !== 2'd0 || busy_a !== 1'b1) begin
            miss++; $display("FAIL start_while_busy: got b=%0d s=%0d busy=%b want 3 0 1", it_a, sc_a, busy_a);
        end
        vecs++;
        is_a = 1'b1;
        for (int k = 0; k < 9; k++) tick();
        is_a = 1'b0;
        if (dn_a !== 1'b1) begin miss++; $display("FAIL end_done: got %b want 1", dn_a); end
        vecs++;
        st_a = 1'b1; tick();
        if (busy_a !== 1'b0) begin miss++; $display("FAIL start_on_done: got busy=%b want 0", busy_a); end
        vecs++;
        tick(); st_a = 1'b0;
        if (busy_a !== 1'b1 || obs_a !== exp_vec(ma, 3)) begin miss++; $display("FAIL start_after_done: got %h want %h", obs_a, exp_vec(ma, 3)); end
        vecs++;
        ab_a = 1'b1; tick(); ab_a = 1'b0;
    endtask

    task automatic test_alternating();
        int wraps = 0, dones = 0;
        logic [3:0] prev;
        st_c = 1'b1; tick(); st_c = 1'b0;
        prev = it_c;
        for (int c = 0; c < 100; c++) begin
            is_c = 1'(c % 2);
            tick();
            if (obs_c !== exp_vec(mc, 5)) begin miss++; $display("FAIL alt_model c=%0d: got %h want %h", c, obs_c, exp_vec(mc, 5)); end
            vecs++;
            if (prev == 4'd15 && it_c == 4'd0) wraps++;
            if (dn_c) dones++;
            prev = it_c;
        end
        is_c = 1'b0;
        if (wraps != 3 || dones != 0 || sc_c !== 3'd3) begin
            miss++; $display("FAIL alt_summary: got wraps=%0d dones=%0d s=%0d want 3 0 3", wraps, dones, sc_c);
        end
        vecs++;
        ab_c = 1'b1; tick(); ab_c = 1'b0;
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            st_a = 1'($urandom % 6 == 0); ab_a = 1'($urandom % 40 == 0); is_a = 1'($urandom % 4 != 0); go_a = 1'($urandom % 3 == 0);
            st_b = 1'($urandom % 6 == 0); ab_b = 1'($urandom % 40 == 0); is_b = 1'($urandom % 4 != 0); go_b = 1'($urandom % 3 == 0);
            st_c = 1'($urandom % 6 == 0); ab_c = 1'($urandom % 80 == 0); is_c = 1'($urandom % 4 != 0); go_c = 1'($urandom % 3 == 0);
            tick();
            if (obs_a !== exp_vec(ma, 3)) begin miss++; $display("FAIL rand_a c=%0d: got %h want %h", c, obs_a, exp_vec(ma, 3)); end
            vecs++;
            if (obs_b !== exp_vec(mb, 3)) begin miss++; $display("FAIL rand_b c=%0d: got %h want %h", c, obs_b, exp_vec(mb, 3)); end
            vecs++;
            if (obs_c !== exp_vec(mc, 5)) begin miss++; $display("FAIL rand_c c=%0d: got %h want %h", c, obs_c, exp_vec(mc, 5)); end
            vecs++;
        end
        {st_a, ab_a, is_a, go_a, st_b, ab_b, is_b, go_b, st_c, ab_c, is_c, go_c} = '0;
    endtask

    initial begin
        {st_a, ab_a, is_a, go_a, st_b, ab_b, is_b, go_b, st_c, ab_c, is_c, go_c} = '0;
        ma = M_RST; mb = M_RST; mc = M_RST;
        test_reset();
        test_full_transform();
        test_addr_table();
        test_wait_hold();
        test_simultaneous();
        test_alternating();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule

// File: doc/fft_iter_sequencer.md
# fft_iter_sequencer

Parametrised iteration and stage sequencer for an in-place radix-2 decimation-in-time FFT of N = 2^LOG2_N points. It counts butterfly iterations within each stage and counts stages within a transform. For every butterfly it generates the top and bottom data-memory addresses and the twiddle-ROM address. It sits between the FFT top-level controller (start/abort, per-stage go) and the butterfly datapath, which issues one iteration_strobe per completed butterfly. It replaces the fixed 5-bit iteration counter with a full stage/iteration/address sequencer.

## Interface
Parameters:
- LOG2_N, 5, transform size exponent; legal range 2..10; N/2 butterflies per stage, LOG2_N stages.
- AUTO_ADVANCE, 1, 1 = next stage starts immediately; 0 = wait for stage_go after each non-final stage.

Derived widths (localparams): ITER_W = LOG2_N-1, STAGE_W = max(1, clog2(LOG2_N)), ADDR_W = LOG2_N, TW_W = LOG2_N-1.

Ports:
- clk  in  1  system clock, rising edge.
- n_reset  in  1  asynchronous, active-low reset.
- start  in  1  begin a transform; honoured in IDLE only.
- abort  in  1  synchronous abort to IDLE from any state.
- iteration_strobe  in  1  one butterfly completed; honoured in RUN only.
- stage_go  in  1  release from WAIT; ignored elsewhere and when AUTO_ADVANCE=1.
- busy  out  1  high in RUN and WAIT.
- stage_strobe  out  1  one-cycle pulse: a stage just completed.
- done  out  1  one-cycle pulse: final stage completed.
- iteration_count_out  out  ITER_W  current butterfly index b within the stage.
- stage_count_out  out  STAGE_W  current stage s.
- top_addr  out  ADDR_W  top butterfly operand address.
- bot_addr  out  ADDR_W  bottom butterfly operand address.
- tw_addr  out  TW_W  twiddle ROM index.

## Operation
- FSM states:
  - IDLE: waits for start.
  - RUN: counts butterflies.
  - WAIT: inter-stage hold; reachable only when AUTO_ADVANCE=0.
- IDLE & start: next state RUN; iteration and stage counters load 0.
- RUN & iteration_strobe, b != N/2-1: b increments.
- RUN & iteration_strobe, b == N/2-1:
  - b wraps to 0.
  - stage_strobe pulses next cycle.
  - If s == LOG2_N-1: s clears to 0, state goes to IDLE, and done pulses together with stage_strobe.
  - Otherwise: s increments; state stays RUN if AUTO_ADVANCE=1, else goes to WAIT.
- WAIT & stage_go: state goes to RUN; counters are unchanged.
- abort takes priority over start, iteration_strobe and stage_go in every state:
  - next state IDLE, b = 0, s = 0.
  - No stage_strobe or done pulse.
  - Any pulse already scheduled for this cycle still completes.
- Address generation is combinational from the registered b and s:
  - span = 1 << s, pos = b & (span-1), group = b >> s.
  - top_addr = (group << (s+1)) | pos.
  - bot_addr = top_addr + span.
  - tw_addr = pos << (LOG2_N-1-s).
  - All arithmetic is unsigned; no overflow is possible within the declared widths.
- The address outputs are also driven in IDLE and WAIT, derived from the current counters; they are meaningful only while busy is high.

## Timing
- Reset values (asynchronous assert): state IDLE, busy 0, stage_strobe 0, done 0, all counts 0, top_addr 0, bot_addr 1, tw_addr 0.
- Counter update latency: a strobe sampled at edge k changes the counts and addresses after edge k, valid for the cycle k→k+1.
- busy rises the cycle after start is sampled.
- busy falls in the same cycle that done pulses.
- One butterfly per cycle is sustained: a continuous strobe completes a transform in LOG2_N·N/2 strobe cycles with AUTO_ADVANCE=1.
- start asserted while busy: ignored.
- start asserted in the same cycle done pulses: ignored, because the FSM is still leaving RUN on that edge. A new start is accepted from the next cycle.
- Reset deasserted mid-transform: the block resumes from IDLE; no partial state is retained.

## Test plan
- Reset: assert n_reset=0 mid-RUN at stage 2, iteration 5, without waiting for a clock edge. Required response: all outputs go to their reset values immediately (bot_addr = 1).
- LOG2_N=3, AUTO_ADVANCE=1, start followed by a continuous strobe:
  - 12 strobes complete the transform.
  - stage_strobe pulses after strobes 4, 8 and 12.
  - done pulses after strobe 12, together with the third stage_strobe.
  - busy falls at the same time.
- LOG2_N=3 address checks:
  - s=0, b=3 → top 6, bot 7, tw 0.
  - s=1, b=1 → top 1, bot 3, tw 2.
  - s=1, b=2 → top 4, bot 6, tw 0.
  - s=2, b=3 → top 3, bot 7, tw 3.
- AUTO_ADVANCE=0:
  - After strobe 4, state is WAIT and stage_count_out = 1.
  - Further strobes are ignored; counts stay at b=0, s=1.
  - stage_go returns the block to RUN, and the next strobe gives b=1.
- Simultaneous events:
  - abort together with iteration_strobe at s=1, b=3 → IDLE, counts 0, no stage_strobe.
  - start while busy → no effect.
- LOG2_N=5 (default), strobe alternating 0/1 for 100 cycles:
  - iteration_count_out wraps 15→0 at each stage boundary.
  - stage_count_out reaches 3, with no done pulse.
